// File: rtl/jericalla_pkg.sv
// Shared definitions for the jericalla issuer: instruction field layout, packing helper
// and the issue FSM state encoding.
package jericalla_pkg;

    localparam int unsigned OP_W    = 3;
    localparam int unsigned RA_W    = 5;
    localparam int unsigned RB_W    = 5;
    localparam int unsigned WA_W    = 4;
    localparam int unsigned INSTR_W = OP_W + RA_W + RB_W + WA_W;

    localparam int unsigned WA_LSB = 0;
    localparam int unsigned RB_LSB = WA_LSB + WA_W;
    localparam int unsigned RA_LSB = RB_LSB + RB_W;
    localparam int unsigned OP_LSB = RA_LSB + RA_W;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ENTRY_W = DATA_W + 1;
    localparam int unsigned HOLD_W  = 4;

    typedef logic [INSTR_W-1:0] instr_t;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDrive  = 2'd1,
        StSample = 2'd2
    } state_t;

    function automatic instr_t pack_instr(input logic [OP_W-1:0] op,
                                          input logic [RA_W-1:0] ra,
                                          input logic [RB_W-1:0] rb,
                                          input logic [WA_W-1:0] wa);
        instr_t i;
        i = '0;
        i[OP_LSB +: OP_W] = op;
        i[RA_LSB +: RA_W] = ra;
        i[RB_LSB +: RB_W] = rb;
        i[WA_LSB +: WA_W] = wa;
        return i;
    endfunction

endpackage

// File: rtl/jericalla_res_fifo.sv
// Result FIFO: {zf, data} entries, read/write pointers plus occupancy count.
// The head entry is always visible on rdata; pushes never bypass to the output.
module jericalla_res_fifo
    import jericalla_pkg::*;
#(
    parameter int unsigned RES_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic               pop,
    output logic [ENTRY_W-1:0] rdata,
    output logic               empty,
    output logic               full
);

    localparam int unsigned PtrW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(RES_DEPTH + 1);

    logic [ENTRY_W-1:0] mem_q [RES_DEPTH];
    logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CntW'(RES_DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    // Power-of-two depth lets the pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        if (do_push && !do_pop)      cnt_d = cnt_q + CntW'(1);
        else if (do_pop && !do_push) cnt_d = cnt_q - CntW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/jericalla_issuer.sv
// Blocking instruction issuer: holds one packed instruction on the datapath for
// HOLD_CYCLES+1 cycles, then captures the datapath result into the result FIFO.
module jericalla_issuer
    import jericalla_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 2,
    parameter int unsigned RES_DEPTH   = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [4:0]    cmd_ra,
    input  logic [4:0]    cmd_rb,
    input  logic [3:0]    cmd_wa,
    output logic [16:0]   instr,
    input  logic [31:0]   data_in,
    input  logic          zf_in,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [31:0]   res_data,
    output logic          res_zf,
    output logic [15:0]   issue_count
);

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    instr_t              instr_q, instr_d;
    logic [15:0]         issue_count_q, issue_count_d;
    logic                push, pop;
    logic                fifo_empty, fifo_full;
    logic [ENTRY_W-1:0]  fifo_rdata;

    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        instr_d       = instr_q;
        issue_count_d = issue_count_q;
        cmd_ready     = 1'b0;
        instr         = '0;
        push          = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Admission needs a free slot so the later SAMPLE push can never overflow.
                cmd_ready = rst_n && !fifo_full;
                if (cmd_valid && cmd_ready) begin
                    instr_d = pack_instr(cmd_op, cmd_ra, cmd_rb, cmd_wa);
                    hold_d  = HOLD_W'(HOLD_CYCLES - 1);
                    state_d = StDrive;
                end
            end
            StDrive: begin
                instr = instr_q;
                if (hold_q == '0) state_d = StSample;
                else              hold_d  = hold_q - HOLD_W'(1);
            end
            StSample: begin
                instr         = instr_q;
                push          = 1'b1;
                issue_count_d = issue_count_q + 16'd1;
                state_d       = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            hold_q        <= '0;
            instr_q       <= '0;
            issue_count_q <= '0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            instr_q       <= instr_d;
            issue_count_q <= issue_count_d;
        end
    end

    assign res_valid   = !fifo_empty;
    assign pop         = res_valid && res_ready;
    assign res_data    = fifo_rdata[DATA_W-1:0];
    assign res_zf      = fifo_rdata[DATA_W];
    assign issue_count = issue_count_q;

    jericalla_res_fifo #(
        .RES_DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata ({zf_in, data_in}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

endmodule

// File: tb/tb_jericalla_issuer.sv
// Self-checking bench for jericalla_issuer: directed scenarios plus random traffic,
// all compared each cycle against a transaction-level model (countdown + result queue).
module tb_jericalla_issuer;

    localparam int H = 2;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [4:0]  cmd_ra;
    logic [4:0]  cmd_rb;
    logic [3:0]  cmd_wa;
    logic [16:0] instr;
    logic [31:0] data_in;
    logic        zf_in;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_zf;
    logic [15:0] issue_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: cycles left for the outstanding instruction, its value, result queue.
    int          remaining;
    logic [16:0] cur;
    logic [32:0] q[$];
    logic [15:0] cnt;

    always #5 clk = ~clk;

    jericalla_issuer #(
        .HOLD_CYCLES (H),
        .RES_DEPTH   (D)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_ra      (cmd_ra),
        .cmd_rb      (cmd_rb),
        .cmd_wa      (cmd_wa),
        .instr       (instr),
        .data_in     (data_in),
        .zf_in       (zf_in),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_zf      (res_zf),
        .issue_count (issue_count)
    );

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [16:0] ei;
        logic        er;
        ei = (remaining > 0) ? cur : 17'b0;
        er = rst_n && (remaining == 0) && (q.size() < D);
        chk("instr", 33'(instr), 33'(ei));
        chk("cmd_ready", 33'(cmd_ready), 33'(er));
        chk("res_valid", 33'(res_valid), 33'(q.size() > 0));
        chk("issue_count", 33'(issue_count), 33'(cnt));
        if (q.size() > 0) begin
            chk("res_data", 33'(res_data), 33'(q[0][31:0]));
            chk("res_zf", 33'(res_zf), 33'(q[0][32]));
        end
    endtask

    task automatic model_step();
        bit          pop;
        bit          push;
        logic [32:0] pv;
        pop  = 0;
        push = 0;
        pv   = '0;
        if (!rst_n) begin
            remaining = 0;
            q.delete();
            cnt = '0;
        end else begin
            pop = (q.size() > 0) && res_ready;
            if (remaining > 0) begin
                if (remaining == 1) begin
                    push = 1;
                    pv   = {zf_in, data_in};
                    cnt  = cnt + 16'd1;
                end
                remaining--;
            end else if (cmd_valid && q.size() < D) begin
                cur       = {cmd_op, cmd_ra, cmd_rb, cmd_wa};
                remaining = H + 1;
            end
            if (pop)  void'(q.pop_front());
            if (push) q.push_back(pv);
        end
    endtask

    // Inputs are set just after a falling edge; outputs are checked before the next rising edge.
    task automatic cycle();
        #1;
        check_all();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic set_cmd(input logic [2:0] op, input logic [4:0] ra, input logic [4:0] rb,
                           input logic [3:0] wa);
        cmd_op = op;
        cmd_ra = ra;
        cmd_rb = rb;
        cmd_wa = wa;
    endtask

    initial begin
        logic [16:0] exp_instr;
        remaining = 0;
        cur       = '0;
        cnt       = '0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        data_in   = '0;
        zf_in     = 1'b0;
        set_cmd(3'd0, 5'd0, 5'd0, 4'd0);
        @(negedge clk);
        cycle();
        cycle();
        chk("reset_cmd_ready", 33'(cmd_ready), 33'(0));
        rst_n = 1'b1;
        cycle();

        // Single command, exact packed value
        exp_instr = 17'b00100100010001101;
        set_cmd(3'b001, 5'd4, 5'd8, 4'd13);
        data_in   = 32'h5;
        zf_in     = 1'b0;
        cmd_valid = 1'b1;
        cycle();
        cmd_valid = 1'b0;
        for (int i = 0; i < H + 1; i++) begin
            chk("single_instr", 33'(instr), 33'(exp_instr));
            cycle();
        end
        chk("single_instr_idle", 33'(instr), 33'(0));
        chk("single_valid", 33'(res_valid), 33'(1));
        chk("single_data", 33'(res_data), 33'(32'h5));
        chk("single_zf", 33'(res_zf), 33'(0));
        chk("single_count", 33'(issue_count), 33'(16'd1));
        res_ready = 1'b1;
        cycle();
        res_ready = 1'b0;

        // Zero result
        data_in   = 32'h0;
        zf_in     = 1'b1;
        set_cmd(3'd5, 5'd1, 5'd2, 4'd3);
        cmd_valid = 1'b1;
        cycle();
        cmd_valid = 1'b0;
        repeat (H + 1) cycle();
        chk("zero_data", 33'(res_data), 33'(0));
        chk("zero_zf", 33'(res_zf), 33'(1));
        res_ready = 1'b1;
        cycle();
        res_ready = 1'b0;
        zf_in = 1'b0;

        // Back-pressure: four results fill the FIFO, a fifth command waits for a pop
        cmd_valid = 1'b1;
        for (int i = 0; i < 4 * (H + 2); i++) begin
            data_in = $urandom;
            set_cmd(3'($urandom), 5'($urandom), 5'($urandom), 4'($urandom));
            cycle();
        end
        repeat (3) begin
            chk("bp_cmd_ready", 33'(cmd_ready), 33'(0));
            chk("bp_instr", 33'(instr), 33'(0));
            cycle();
        end
        res_ready = 1'b1;
        cycle();
        res_ready = 1'b0;
        chk("bp_ready_after_pop", 33'(cmd_ready), 33'(1));
        cycle();
        cmd_valid = 1'b0;
        repeat (H + 2) cycle();
        res_ready = 1'b1;
        repeat (D + 1) cycle();
        res_ready = 1'b0;

        // Simultaneous push and pop with one entry held
        data_in   = 32'hAAAA_0001;
        set_cmd(3'd2, 5'd10, 5'd11, 4'd1);
        cmd_valid = 1'b1;
        cycle();
        cmd_valid = 1'b0;
        repeat (H + 1) cycle();
        data_in   = 32'hBBBB_0002;
        set_cmd(3'd3, 5'd12, 5'd13, 4'd2);
        cmd_valid = 1'b1;
        cycle();
        cmd_valid = 1'b0;
        repeat (H) cycle();
        res_ready = 1'b1;
        cycle();
        res_ready = 1'b0;
        chk("pp_valid", 33'(res_valid), 33'(1));
        chk("pp_order", 33'(res_data), 33'(32'hBBBB_0002));
        res_ready = 1'b1;
        cycle();
        res_ready = 1'b0;
        chk("pp_drained", 33'(res_valid), 33'(0));

        // Reset mid-DRIVE
        data_in   = 32'h1234;
        cmd_valid = 1'b1;
        cycle();
        cmd_valid = 1'b0;
        rst_n     = 1'b0;
        cycle();
        rst_n = 1'b1;
        chk("rst_instr", 33'(instr), 33'(0));
        chk("rst_valid", 33'(res_valid), 33'(0));
        chk("rst_count", 33'(issue_count), 33'(0));
        repeat (H + 3) cycle();
        chk("rst_no_result", 33'(res_valid), 33'(0));

        // Counter wrap from a preloaded value
        force dut.issue_count_q = 16'hFFFE;
        cnt = 16'hFFFE;
        cycle();
        release dut.issue_count_q;
        cycle();
        res_ready = 1'b1;
        cmd_valid = 1'b1;
        cycle();
        cmd_valid = 1'b0;
        repeat (H + 1) cycle();
        chk("wrap_ffff", 33'(issue_count), 33'(16'hFFFF));
        cmd_valid = 1'b1;
        cycle();
        cmd_valid = 1'b0;
        repeat (H + 1) cycle();
        chk("wrap_zero", 33'(issue_count), 33'(16'h0000));

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            cmd_valid = ($urandom_range(0, 2) != 0);
            res_ready = ($urandom_range(0, 2) == 0);
            data_in   = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            zf_in     = 1'($urandom);
            set_cmd(3'($urandom), 5'($urandom), 5'($urandom), 4'($urandom));
            cycle();
        end
        rst_n = 1'b1;
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
